bean_dec_chan_sched: RTL and testbench
======================================

# bean_dec_chan_sched

Schedules instruction words from the BEAN fetch stage into the decoder's 4-deep channel bank. It keeps channels in fetch order, presents the oldest to the decoder through a valid/ready handshake, and reports per-channel empty flags. It also flushes every channel on a pipeline `drop`. It sits between the fetch unit and `Decoder`, and is the only writer of decoder channel state.

## Interface
Parameters:
- `XPR_LEN`, 32, instruction/PC word width
- `DEPTH`, 4, number of decoder channels; power of two, ≥2
- `CW`, $clog2(DEPTH+1), occupancy counter width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `fetch_valid`  in  1  fetch offers a word
- `fetch_ready`  out  1  scheduler accepts a word this cycle
- `fetch_instr`  in  XPR_LEN  instruction word
- `fetch_pc`  in  XPR_LEN  PC of that word
- `dec_valid`  out  1  oldest channel presented to decoder
- `dec_ready`  in  1  decoder consumes the presented word
- `dec_instr`  out  XPR_LEN  oldest instruction
- `dec_pc`  out  XPR_LEN  oldest PC
- `drop`  in  1  flush request (branch mispredict / trap)
- `chan_empty`  out  DEPTH  bit i = 1 when physical channel i holds no word
- `count`  out  CW  number of occupied channels

## Operation
- Storage is a circular buffer of DEPTH slots (instr + pc + valid bit), with write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits. Both pointers wrap modulo DEPTH.
- Enqueue occurs when `fetch_valid && fetch_ready`: write slot[wp], set its valid bit, wp++.
- Dequeue occurs when `dec_valid && dec_ready`: clear slot[rp] valid bit, rp++.
- Simultaneous enqueue and dequeue leaves `count` unchanged. Otherwise `count` changes by ±1.
- `fetch_ready` = state≠FLUSH && count<DEPTH && !drop && !rst. It is independent of `dec_ready`, so no combinational path runs from decoder to fetch. When full, the scheduler refuses fetch even if a dequeue happens in the same cycle.
- `dec_valid` = count>0 && state≠FLUSH && !drop. `dec_instr`/`dec_pc` = slot[rp].
- `chan_empty[i]` = !slot[i].valid, registered.
- FSM states:
  - IDLE (count==0)
  - ACTIVE (count>0)
  - FLUSH
- FSM transitions:
  - IDLE→ACTIVE on enqueue.
  - ACTIVE→IDLE when a dequeue empties the buffer with no enqueue.
  - Any state→FLUSH when `drop`=1.
  - FLUSH→IDLE after one cycle if `drop`=0. FLUSH stays in FLUSH while `drop`=1.
- `drop` takes priority over everything. In the drop cycle no transfer completes on either side. At the clock edge, all valid bits clear, wp=rp=0, count=0.
- Slot payload registers are not reset; only valid bits, pointers, count and state are reset.

## Timing
- Reset values (registered outputs): `count`=0, `chan_empty`=all 1s, state=IDLE.
- While `rst`=1: `fetch_ready`=0 and `dec_valid`=0.
- First cycle after reset: `fetch_ready`=1, `dec_valid`=0.
- Latency (macro off): a word enqueued at edge N is on `dec_*` with `dec_valid`=1 in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Handshake: `dec_instr`/`dec_pc` are stable while `dec_valid`=1 and `dec_ready`=0, except when `drop` asserts, which withdraws `dec_valid`.
- Drop: the drop cycle and the FLUSH cycle both show `fetch_ready`=0 and `dec_valid`=0. Fetch is accepted again 2 cycles after `drop` is first sampled high.
- Reset mid-operation behaves as `drop`, but returns directly to IDLE with no FLUSH cycle.

## Configuration
- `BEAN_DECSCHED_BYPASS_EN` defined:
  - When state=IDLE (count==0), `dec_valid`=`fetch_valid` and `dec_*`=`fetch_*` combinationally.
  - If `dec_ready`=1 the word passes through without being written, giving zero latency.
  - If `dec_ready`=0 the word is enqueued normally.
  - `drop` still blocks the bypass.
- Undefined: no fetch→decode combinational path; minimum latency is 1 cycle.

## Test plan
- Reset, then 4 enqueues (instr 0x11..0x14, `dec_ready`=0) → `count`=4, `chan_empty`=4'b0000, `fetch_ready`=0, `dec_instr`=0x11.
- Full buffer, then `dec_ready`=1 for 4 cycles → outputs 0x11,0x12,0x13,0x14 in order. `count` ends at 0, `chan_empty`=4'b1111, and `fetch_ready`=1 from the cycle after the first dequeue.
- Continuous fetch and `dec_ready`=1 for 10 words → one word per cycle. `count` stays at 1; pointers wrap past slot 3 with PCs in order.
- 3 words queued, `drop` pulsed 1 cycle while `fetch_valid`=1 → no transfer in the drop cycle. FLUSH next cycle, `count`=0, `chan_empty`=4'b1111, `fetch_ready`=1 two cycles after the drop.
- `drop` held 3 cycles → state stays FLUSH, `fetch_ready`=0 throughout, IDLE one cycle after release.
- Empty buffer with `fetch_valid`=1, instr 0xA5, `dec_ready`=1 → with the macro, `dec_valid`=1 and `dec_instr`=0xA5 in the same cycle and `count` stays 0. Without it, the word appears next cycle.

Source files
------------

// File: rtl/bean_dec_chan_sched.sv
// Decoder channel scheduler: in-order 4-slot circular buffer between fetch and decode.
// Define BEAN_DECSCHED_BYPASS_EN for a zero-latency fetch->decode pass-through when empty.
module bean_dec_chan_sched #(
  parameter int XPR_LEN = 32,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [XPR_LEN-1:0] fetch_instr,
  input  logic [XPR_LEN-1:0] fetch_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [XPR_LEN-1:0] dec_instr,
  output logic [XPR_LEN-1:0] dec_pc,
  input  logic               drop,
  output logic [DEPTH-1:0]   chan_empty,
  output logic [CW-1:0]      count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  state_t             r_state;
  logic [XPR_LEN-1:0] r_instr [DEPTH];
  logic [XPR_LEN-1:0] r_pc    [DEPTH];
  logic [DEPTH-1:0]   r_empty;
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_count;

  logic          w_qvalid;
  logic          w_byp;
  logic          w_enq;
  logic          w_deq;
  logic [CW-1:0] w_count_nxt;

  assign fetch_ready = (r_state != S_FLUSH) && (r_count < CW'(DEPTH))
                     && !drop && !rst;

  assign w_qvalid = (r_count != '0) && (r_state != S_FLUSH)
                  && !drop && !rst;

`ifdef BEAN_DECSCHED_BYPASS_EN
  assign w_byp = (r_state == S_IDLE) && fetch_valid && !drop && !rst;
`else
  assign w_byp = 1'b0;
`endif

  assign dec_valid = w_qvalid || w_byp;
  assign dec_instr = w_byp ? fetch_instr : r_instr[r_rp];
  assign dec_pc    = w_byp ? fetch_pc    : r_pc[r_rp];

  // A bypassed word that the decoder takes is never written
  assign w_enq = fetch_valid && fetch_ready && !(w_byp && dec_ready);
  assign w_deq = w_qvalid && dec_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_deq)
      w_count_nxt = r_count + CW'(1);
    else if (w_deq && !w_enq)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_instr[r_wp] <= fetch_instr;
      r_pc[r_wp]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_empty <= '1;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (drop) begin
      r_state <= S_FLUSH;
      r_empty <= '1;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_empty[r_wp] <= 1'b0;
        r_wp          <= r_wp + PW'(1);
      end
      if (w_deq) begin
        r_empty[r_rp] <= 1'b1;
        r_rp          <= r_rp + PW'(1);
      end
      r_count <= w_count_nxt;
      unique case (r_state)
        S_FLUSH:  r_state <= S_IDLE;
        S_IDLE:   if (w_enq) r_state <= S_ACTIVE;
        S_ACTIVE: if (w_count_nxt == '0) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign chan_empty = r_empty;
  assign count      = r_count;

endmodule

// File: tb/tb_bean_dec_chan_sched.sv
// Bench for bean_dec_chan_sched: directed scenarios plus randomized traffic
// checked against a queue-based model of the channel bank.
module tb_bean_dec_chan_sched;

  localparam int XL = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0;
  logic          fetch_ready;
  logic [XL-1:0] fetch_instr = '0;
  logic [XL-1:0] fetch_pc = '0;
  logic          dec_valid;
  logic          dec_ready = 1'b0;
  logic [XL-1:0] dec_instr;
  logic [XL-1:0] dec_pc;
  logic          drop = 1'b0;
  logic [D-1:0]  chan_empty;
  logic [CW-1:0] count;

  int n_run  = 0;
  int n_fail = 0;

  bean_dec_chan_sched #(.XPR_LEN(XL), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .drop(drop), .chan_empty(chan_empty), .count(count)
  );

  always #5 clk = ~clk;

  // Model: queue of {pc, instr} in fetch order, physical slot of the oldest
  logic [2*XL-1:0] mq[$];
  int  m_head  = 0;
  bit  m_flush = 0;

`ifdef BEAN_DECSCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit m_fready();
    return !m_flush && mq.size() < D && !drop && !rst;
  endfunction

  function automatic bit m_qvalid();
    return mq.size() > 0 && !m_flush && !drop && !rst;
  endfunction

  function automatic bit m_byp();
    return BYP && mq.size() == 0 && !m_flush && fetch_valid && !drop && !rst;
  endfunction

  function automatic logic [D-1:0] m_empty();
    logic [D-1:0] e;
    e = '1;
    for (int k = 0; k < mq.size(); k++) e[(m_head + k) % D] = 1'b0;
    return e;
  endfunction

  task automatic model_update();
    bit deq, enq;
    if (rst) begin
      mq.delete(); m_head = 0; m_flush = 0;
    end else if (drop) begin
      mq.delete(); m_head = 0; m_flush = 1;
    end else begin
      deq = m_qvalid() && dec_ready;
      enq = fetch_valid && m_fready() && !(m_byp() && dec_ready);
      m_flush = 0;
      if (deq) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % D;
      end
      if (enq) mq.push_back({fetch_pc, fetch_instr});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(bit fv, logic [XL-1:0] ins, logic [XL-1:0] pc,
                       bit dr, bit dp);
    fetch_valid = fv; fetch_instr = ins; fetch_pc = pc;
    dec_ready = dr; drop = dp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h99, 32'h0, 1, 0);
    tick(); tick();
    #1;
    n_run++;
    if (fetch_ready !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: fready=%b dvalid=%b want 0 0", fetch_ready, dec_valid);
    end
    n_run++;
    if (count !== 0 || chan_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_regs: count=%0d empty=%b want 0 1111", count, chan_empty);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (fetch_ready !== 1'b1 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first: fready=%b dvalid=%b want 1 0", fetch_ready, dec_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h11 + i, 32'h100 + 4*i, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (count !== 4 || chan_empty !== 4'b0000) begin
      n_fail++;
      $display("FAIL fill_occ: count=%0d empty=%b want 4 0000", count, chan_empty);
    end
    n_run++;
    if (fetch_ready !== 1'b0 || dec_valid !== 1'b1 || dec_instr !== 32'h11) begin
      n_fail++;
      $display("FAIL fill_head: fready=%b dvalid=%b instr=%h want 0 1 11",
               fetch_ready, dec_valid, dec_instr);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      #1;
      n_run++;
      if (dec_valid !== 1'b1 || dec_instr !== 32'h11 + i) begin
        n_fail++;
        $display("FAIL drain_word%0d: dvalid=%b instr=%h want 1 %h",
                 i, dec_valid, dec_instr, 32'h11 + i);
      end
      n_run++;
      if (fetch_ready !== (i != 0)) begin
        n_fail++;
        $display("FAIL drain_fready%0d: got %b want %b", i, fetch_ready, i != 0);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (count !== 0 || chan_empty !== 4'hF || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: count=%0d empty=%b dvalid=%b want 0 1111 0",
               count, chan_empty, dec_valid);
    end
  endtask

  task automatic test_stream();
    int got = 0;
    for (int i = 0; i < 14 && got < 10; i++) begin
      if (i < 10) drive(1, 32'hC0 + i, 32'h1000 + 4*i, 1, 0);
      else drive(0, 0, 0, 1, 0);
      #1;
      if (i < 10) begin
        n_run++;
        if (fetch_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_fready%0d: got %b want 1", i, fetch_ready);
        end
      end
      if (i >= 1 && i < 10) begin
        n_run++;
        if (count !== (BYP ? 0 : 1)) begin
          n_fail++;
          $display("FAIL stream_count%0d: got %0d want %0d", i, count, BYP ? 0 : 1);
        end
      end
      if (dec_valid && dec_ready) begin
        n_run++;
        if (dec_pc !== 32'h1000 + 4*got || dec_instr !== 32'hC0 + got) begin
          n_fail++;
          $display("FAIL stream_order%0d: pc=%h instr=%h want %h %h",
                   got, dec_pc, dec_instr, 32'h1000 + 4*got, 32'hC0 + got);
        end
        got++;
      end
      tick();
    end
    n_run++;
    if (got != 10) begin
      n_fail++;
      $display("FAIL stream_total: got %0d words want 10", got);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h50 + i, 32'h2000 + 4*i, 0, 0);
      tick();
    end
    drive(1, 32'h77, 32'h3000, 1, 1);
    #1;
    n_run++;
    if (fetch_ready !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_cycle: fready=%b dvalid=%b want 0 0", fetch_ready, dec_valid);
    end
    tick();
    drive(1, 32'h78, 32'h3004, 1, 0);
    #1;
    n_run++;
    if (fetch_ready !== 1'b0 || dec_valid !== 1'b0 ||
        count !== 0 || chan_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL drop_flush: fready=%b dvalid=%b count=%0d empty=%b want 0 0 0 1111",
               fetch_ready, dec_valid, count, chan_empty);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (fetch_ready !== 1'b1 || count !== 0) begin
      n_fail++;
      $display("FAIL drop_resume: fready=%b count=%0d want 1 0", fetch_ready, count);
    end
  endtask

  task automatic test_drop_hold();
    drive(1, 32'h60, 32'h4000, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h61, 32'h4004, 1, 1);
      #1;
      n_run++;
      if (fetch_ready !== 1'b0 || dec_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_drop%0d: fready=%b dvalid=%b want 0 0", i, fetch_ready, dec_valid);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (fetch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_flush: fready=%b want 0", fetch_ready);
    end
    tick();
    #1;
    n_run++;
    if (fetch_ready !== 1'b1 || chan_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL hold_idle: fready=%b empty=%b want 1 1111", fetch_ready, chan_empty);
    end
  endtask

  task automatic test_bypass();
    drive(1, 32'hA5, 32'h5000, 1, 0);
    #1;
    n_run++;
    if (dec_valid !== BYP || (BYP && dec_instr !== 32'hA5)) begin
      n_fail++;
      $display("FAIL byp_same: dvalid=%b instr=%h want %b a5", dec_valid, dec_instr, BYP);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_run++;
    if (count !== (BYP ? 0 : 1) || dec_valid !== !BYP ||
        (!BYP && dec_instr !== 32'hA5)) begin
      n_fail++;
      $display("FAIL byp_next: count=%0d dvalid=%b instr=%h want %0d %b a5",
               count, dec_valid, dec_instr, BYP ? 0 : 1, !BYP);
    end
    dec_ready = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 5);
      #1;
      n_run++;
      if (fetch_ready !== m_fready()) begin
        n_fail++;
        $display("FAIL rnd_fready c%0d: got %b want %b", c, fetch_ready, m_fready());
      end
      n_run++;
      if (dec_valid !== (m_qvalid() || m_byp())) begin
        n_fail++;
        $display("FAIL rnd_dvalid c%0d: got %b want %b", c, dec_valid, m_qvalid() || m_byp());
      end
      if (m_byp()) begin
        n_run++;
        if (dec_instr !== fetch_instr || dec_pc !== fetch_pc) begin
          n_fail++;
          $display("FAIL rnd_byp c%0d: instr=%h pc=%h want %h %h",
                   c, dec_instr, dec_pc, fetch_instr, fetch_pc);
        end
      end else if (m_qvalid()) begin
        n_run++;
        if ({dec_pc, dec_instr} !== mq[0]) begin
          n_fail++;
          $display("FAIL rnd_head c%0d: got %h want %h", c, {dec_pc, dec_instr}, mq[0]);
        end
      end
      n_run++;
      if (count !== CW'(mq.size()) || chan_empty !== m_empty()) begin
        n_fail++;
        $display("FAIL rnd_occ c%0d: count=%0d empty=%b want %0d %b",
                 c, count, chan_empty, mq.size(), m_empty());
      end
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_drop();
    test_drop_hold();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
